otter_run_ctrl: RTL and testbench

Synthesizable run controller that sits between the board/bench clock-reset source and the Otter CPU top level. Parametrised successor to the fixed clock/reset/IOBUS bench harness:
- stretches reset for a configurable number of cycles;
- generates periodic and externally requested interrupts;
- decodes IOBUS writes into NUM_CH captured output channels;
- ends the run on a tohost write or a cycle timeout.

---
 rtl/otter_run_pkg.sv | 44 ++++
 rtl/otter_intr_gen.sv | 98 +++++++++
 rtl/otter_run_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_otter_run_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otter_run_pkg
// Description : Shared types, default addresses and the IOBUS channel decode
//               helper for the Otter run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package otter_run_pkg;

    // Run controller states; FINISH and TIMEOUT are terminal until reset.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FINISH  = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_t;

    localparam logic [31:0] c_ch_base_default     = 32'h1100_0000;
    localparam logic [31:0] c_tohost_addr_default = 32'h1100_FFF0;
    localparam int unsigned c_max_ch              = 16;

    // Result of decoding an address against the channel window.
    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } ch_hit_t;

    // Word-aligned offsets below num_ch words hit; anything below the base
    // wraps to a huge offset and therefore misses as well.
    function automatic ch_hit_t chan_decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned num_ch
    );
        ch_hit_t     res;
        logic [31:0] off;
        off     = addr - base;
        res.hit = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < num_ch);
        res.idx = off[5:2];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_intr_gen.sv
`default_nettype none
// ============================================================================
// Module      : otter_intr_gen
// Description : Interrupt pulse generator. Triggers come from a periodic
//               counter and from rising edges of INTR_REQ; a trigger during a
//               pulse is remembered in one pending flag and replayed as a
//               back-to-back pulse when the current one ends.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_intr_gen #(
    parameter int unsigned INTR_PERIOD = 0,
    parameter int unsigned INTR_WIDTH  = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    input  logic INTR_REQ,
    output logic INTR
);

    logic [31:0] r_per_cnt;
    logic [31:0] r_width_cnt;
    logic        r_req_prev;
    logic        r_pulse;
    logic        r_pending;

    logic        w_per_exp;
    logic        w_req_rise;
    logic        w_trig;
    logic        w_last;

    // Trigger sources; a simultaneous periodic expiry and request edge is a
    // single trigger because they are simply OR-ed together.
    always_comb begin
        w_per_exp  = (INTR_PERIOD != 0) && enable &&
                     (r_per_cnt == 32'(INTR_PERIOD - 1));
        w_req_rise = enable && INTR_REQ && !r_req_prev;
        w_trig     = w_per_exp || w_req_rise;
        w_last     = (r_width_cnt == 32'(INTR_WIDTH - 1));
    end

    // Period counter restarts from zero whenever the generator is disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_per_cnt <= '0;
        end else if (!enable || w_per_exp) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + 32'd1;
        end
    end

    // Previous INTR_REQ sample for edge detection; tracks even when disabled
    // so a level already high on entry to RUN is not seen as an edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_req_prev <= 1'b0;
        end else begin
            r_req_prev <= INTR_REQ;
        end
    end

    // Pulse length counter and pending flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pulse     <= 1'b0;
            r_width_cnt <= '0;
            r_pending   <= 1'b0;
        end else if (!enable) begin
            r_pulse     <= 1'b0;
            r_width_cnt <= '0;
            r_pending   <= 1'b0;
        end else if (!r_pulse) begin
            if (w_trig) begin
                r_pulse     <= 1'b1;
                r_width_cnt <= '0;
            end
        end else if (w_last) begin
            // Last cycle of the pulse: a pending or fresh trigger continues
            // straight into a new full-width pulse.
            if (r_pending || w_trig) begin
                r_width_cnt <= '0;
                r_pending   <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
            end
        end else begin
            r_width_cnt <= r_width_cnt + 32'd1;
            if (w_trig) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign INTR = r_pulse && enable;

endmodule
`default_nettype wire

// File: rtl/otter_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : otter_run_ctrl
// Description : Run controller between the clock/reset source and the Otter
//               CPU: stretches reset, generates interrupts, captures IOBUS
//               writes into output channels and ends the run on a tohost
//               write or a cycle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_run_ctrl
    import otter_run_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 15,
    parameter int unsigned INTR_PERIOD = 0,
    parameter int unsigned INTR_WIDTH  = 1,
    parameter int unsigned NUM_CH      = 4,
    parameter logic [31:0] CH_BASE     = c_ch_base_default,
    parameter logic [31:0] TOHOST_ADDR = c_tohost_addr_default,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            IOBUS_ADDR,
    input  logic [31:0]            IOBUS_OUT,
    input  logic                   IOBUS_WR,
    input  logic                   INTR_REQ,
    output logic                   CPU_RST,
    output logic                   INTR,
    output logic [32*NUM_CH-1:0]   CH_DATA,
    output logic [NUM_CH-1:0]      CH_VALID,
    output logic [31:0]            WR_COUNT,
    output logic                   DONE,
    output logic                   PASS,
    output logic                   TIMED_OUT
);

    run_state_t  r_state;
    run_state_t  w_state_nxt;

    logic [31:0] r_hold_cnt;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_wr_count;
    logic        r_cpu_rst;
    logic        r_done;
    logic        r_timed_out;
    logic        r_pass;

    ch_hit_t     w_dec;
    logic        w_run;
    logic        w_tohost_wr;
    logic        w_ch_wr;
    logic        w_hold_done;
    logic        w_timeout_hit;

    // Bus decode; tohost takes precedence over a channel at the same address.
    always_comb begin
        w_run         = (r_state == ST_RUN);
        w_dec         = chan_decode(IOBUS_ADDR, CH_BASE, NUM_CH);
        w_tohost_wr   = w_run && IOBUS_WR && (IOBUS_ADDR == TOHOST_ADDR);
        w_ch_wr       = w_run && IOBUS_WR && w_dec.hit &&
                        (IOBUS_ADDR != TOHOST_ADDR);
        w_hold_done   = (r_hold_cnt == 32'(RST_CYCLES - 1));
        w_timeout_hit = (TIMEOUT != 0) && (r_cyc_cnt == 32'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a tohost write beats a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tohost_wr) begin
                    w_state_nxt = ST_FINISH;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // Status outputs registered from the next state so they change cleanly
    // on the deciding edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_cpu_rst   <= (w_state_nxt != ST_RUN);
            r_done      <= (w_state_nxt == ST_FINISH);
            r_timed_out <= (w_state_nxt == ST_TIMEOUT);
        end
    end

    // Reset stretch counter, active only while holding the CPU in reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
        end
    end

    // RUN-state cycle counter used for the timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cyc_cnt <= '0;
        end else if (w_run) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    // PASS is latched from the tohost data word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pass <= 1'b0;
        end else if (w_tohost_wr) begin
            r_pass <= (IOBUS_OUT == 32'd1);
        end
    end

    // Accepted channel write counter, free to wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_count <= '0;
        end else if (w_ch_wr) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    // One capture register and valid strobe per channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [31:0] r_data;
        logic        r_valid;
        logic        w_sel;

        assign w_sel = w_ch_wr && (w_dec.idx == 4'(gi));

        // Load on a hit for this channel; the strobe lasts one cycle.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_sel;
                if (w_sel) begin
                    r_data <= IOBUS_OUT;
                end
            end
        end

        assign CH_DATA[32*gi +: 32] = r_data;
        assign CH_VALID[gi]         = r_valid;
    end

    otter_intr_gen #(
        .INTR_PERIOD (INTR_PERIOD),
        .INTR_WIDTH  (INTR_WIDTH)
    ) u_intr_gen (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (w_run),
        .INTR_REQ (INTR_REQ),
        .INTR     (INTR)
    );

    assign CPU_RST   = r_cpu_rst;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign TIMED_OUT = r_timed_out;
    assign WR_COUNT  = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_otter_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_run_ctrl
// Description : Self-checking bench for otter_run_ctrl: vector table for the
//               channel decode, directed multi-cycle sequences and random
//               traffic against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_run_ctrl;

    localparam int unsigned RST_CYCLES  = 15;
    localparam int unsigned INTR_PERIOD = 10;
    localparam int unsigned INTR_WIDTH  = 3;
    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned TIMEOUT     = 100;
    localparam logic [31:0] CH_BASE     = 32'h1100_0000;
    localparam logic [31:0] TOHOST      = 32'h1100_FFF0;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic [31:0]          IOBUS_ADDR = '0;
    logic [31:0]          IOBUS_OUT = '0;
    logic                 IOBUS_WR = 1'b0;
    logic                 INTR_REQ = 1'b0;
    logic                 CPU_RST;
    logic                 INTR;
    logic [32*NUM_CH-1:0] CH_DATA;
    logic [NUM_CH-1:0]    CH_VALID;
    logic [31:0]          WR_COUNT;
    logic                 DONE;
    logic                 PASS;
    logic                 TIMED_OUT;

    int checks   = 0;
    int failures = 0;

    otter_run_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .INTR_PERIOD (INTR_PERIOD),
        .INTR_WIDTH  (INTR_WIDTH),
        .NUM_CH      (NUM_CH),
        .CH_BASE     (CH_BASE),
        .TOHOST_ADDR (TOHOST),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .INTR_REQ   (INTR_REQ),
        .CPU_RST    (CPU_RST),
        .INTR       (INTR),
        .CH_DATA    (CH_DATA),
        .CH_VALID   (CH_VALID),
        .WR_COUNT   (WR_COUNT),
        .DONE       (DONE),
        .PASS       (PASS),
        .TIMED_OUT  (TIMED_OUT)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int          m_hold;
    int          m_r;         // RUN edges seen so far
    int          m_last_hi;   // last RUN edge after which INTR is high
    bit          m_running, m_done, m_tmo, m_pass, m_pend, m_req_prev, m_intr;
    logic [31:0] m_data [NUM_CH];
    logic [NUM_CH-1:0] m_valid;
    logic [31:0] m_count;

    task automatic model_reset();
        m_hold = 0; m_r = 0; m_last_hi = -1;
        m_running = 0; m_done = 0; m_tmo = 0; m_pass = 0;
        m_pend = 0; m_req_prev = 0; m_intr = 0;
        for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
        m_valid = '0; m_count = '0;
    endtask

    task automatic model_edge();
        bit rise, trig, cur_high;
        if (RST) return;
        rise = INTR_REQ && !m_req_prev;
        m_req_prev = INTR_REQ;
        m_valid = '0;
        if (m_running) begin
            m_r++;
            trig = ((m_r % INTR_PERIOD) == 0) || rise;
            cur_high = (m_r - 1) <= m_last_hi;
            if (!cur_high) begin
                if (trig) m_last_hi = m_r + INTR_WIDTH - 1;
            end else if (m_r == m_last_hi + 1) begin
                if (m_pend || trig) begin
                    m_last_hi = m_r + INTR_WIDTH - 1;
                    m_pend = 0;
                end
            end else if (trig) begin
                m_pend = 1;
            end
            if (IOBUS_WR && IOBUS_ADDR == TOHOST) begin
                m_done = 1; m_pass = (IOBUS_OUT == 32'd1); m_running = 0;
            end else begin
                if (IOBUS_WR) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (IOBUS_ADDR == CH_BASE + 32'(4 * i)) begin
                            m_data[i] = IOBUS_OUT; m_valid[i] = 1'b1; m_count++;
                        end
                    end
                end
                if (m_r == TIMEOUT) begin
                    m_tmo = 1; m_running = 0;
                end
            end
        end else if (!m_done && !m_tmo) begin
            m_hold++;
            if (m_hold == RST_CYCLES) m_running = 1;
        end
        m_intr = m_running && (m_r <= m_last_hi);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [127:0] exp_data;
        exp_data = '0;
        for (int i = 0; i < NUM_CH; i++) exp_data[32*i +: 32] = m_data[i];
        chk(tag, "CPU_RST",   128'(CPU_RST),   128'(!m_running));
        chk(tag, "INTR",      128'(INTR),      128'(m_intr));
        chk(tag, "CH_DATA",   128'(CH_DATA),   exp_data);
        chk(tag, "CH_VALID",  128'(CH_VALID),  128'(m_valid));
        chk(tag, "WR_COUNT",  128'(WR_COUNT),  128'(m_count));
        chk(tag, "DONE",      128'(DONE),      128'(m_done));
        chk(tag, "PASS",      128'(PASS),      128'(m_pass));
        chk(tag, "TIMED_OUT", 128'(TIMED_OUT), 128'(m_tmo));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_bus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = data;
    endtask

    task automatic apply_reset(input int n);
        RST = 1'b1; IOBUS_WR = 1'b0; INTR_REQ = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (n) step("reset");
        RST = 1'b0;
    endtask

    task automatic run_to_run();
        apply_reset(2);
        repeat (RST_CYCLES) step("hold");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   exp_valid;
        logic [31:0]  exp_count;
        logic [127:0] exp_data;
    } vec_t;

    vec_t tbl [8];

    initial begin
        forever begin
            #1_000_000;
            $display("FAIL watchdog simulation time limit reached");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        tbl[0] = '{1'b1, CH_BASE + 32'd8,  32'hDEAD_BEEF, 4'b0100, 32'd1,
                   {32'h0, 32'hDEAD_BEEF, 64'h0}};
        tbl[1] = '{1'b1, CH_BASE + 32'd2,  32'h1111_1111, 4'b0000, 32'd1,
                   {32'h0, 32'hDEAD_BEEF, 64'h0}};
        tbl[2] = '{1'b1, CH_BASE + 32'd16, 32'h2222_2222, 4'b0000, 32'd1,
                   {32'h0, 32'hDEAD_BEEF, 64'h0}};
        tbl[3] = '{1'b1, CH_BASE + 32'd0,  32'hA5A5_A5A5, 4'b0001, 32'd2,
                   {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hA5A5_A5A5}};
        tbl[4] = '{1'b1, CH_BASE + 32'd12, 32'h1234_5678, 4'b1000, 32'd3,
                   {32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 32'hA5A5_A5A5}};
        tbl[5] = '{1'b0, CH_BASE + 32'd4,  32'h3333_3333, 4'b0000, 32'd3,
                   {32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 32'hA5A5_A5A5}};
        tbl[6] = '{1'b1, CH_BASE - 32'd4,  32'h4444_4444, 4'b0000, 32'd3,
                   {32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 32'hA5A5_A5A5}};
        tbl[7] = '{1'b1, CH_BASE + 32'd4,  32'h5555_5555, 4'b0010, 32'd4,
                   {32'h1234_5678, 32'hDEAD_BEEF, 32'h5555_5555, 32'hA5A5_A5A5}};

        #2;
        // Reset hold: CPU_RST falls exactly after the 15th edge.
        apply_reset(5);
        for (int k = 1; k <= int'(RST_CYCLES); k++) begin
            step("hold");
            if (k == int'(RST_CYCLES) - 1) chk("hold", "cpu_rst_e14", 128'(CPU_RST), 128'(1'b1));
            if (k == int'(RST_CYCLES))     chk("hold", "cpu_rst_e15", 128'(CPU_RST), 128'(1'b0));
        end

        // Channel decode vectors.
        for (int v = 0; v < 8; v++) begin
            set_bus(tbl[v].wr, tbl[v].addr, tbl[v].data);
            step("tbl");
            chk("tbl", "valid", 128'(CH_VALID), 128'(tbl[v].exp_valid));
            chk("tbl", "count", 128'(WR_COUNT), 128'(tbl[v].exp_count));
            chk("tbl", "data",  CH_DATA,        tbl[v].exp_data);
            set_bus(1'b0, '0, '0);
            step("tbl_idle");
            chk("tbl", "valid_clr", 128'(CH_VALID), 128'(4'b0000));
        end

        // Interrupt merge: periodic at 10/20/30, requests at 11, 21 and 23.
        run_to_run();
        for (int e = 1; e <= 31; e++) begin
            bit exp_i;
            INTR_REQ = (e == 11 || e == 21 || e == 23);
            step("merge");
            exp_i = (e >= 10 && e <= 15) || (e >= 20 && e <= 25) || (e >= 30);
            chk("merge", $sformatf("intr_e%0d", e), 128'(INTR), 128'(exp_i));
        end
        INTR_REQ = 1'b0;

        // Tohost pass and fail.
        for (int t = 0; t < 2; t++) begin
            run_to_run();
            set_bus(1'b1, CH_BASE + 32'd4, 32'hCAFE_0001);
            step("tohost");
            set_bus(1'b1, TOHOST, (t == 0) ? 32'd1 : 32'd2);
            step("tohost");
            chk("tohost", "done",    128'(DONE),    128'(1'b1));
            chk("tohost", "pass",    128'(PASS),    128'((t == 0) ? 1'b1 : 1'b0));
            chk("tohost", "cpu_rst", 128'(CPU_RST), 128'(1'b1));
            set_bus(1'b1, CH_BASE + 32'd4, 32'hBAD0_BAD0);
            step("tohost");
            chk("tohost", "ignored_cnt", 128'(WR_COUNT), 128'(32'd1));
            chk("tohost", "ignored_vld", 128'(CH_VALID), 128'(4'b0000));
            chk("tohost", "ignored_dat", 128'(CH_DATA[63:32]), 128'(32'hCAFE_0001));
            set_bus(1'b0, '0, '0);
            step("tohost");
        end

        // Timeout, then timeout tied with a tohost write.
        run_to_run();
        repeat (int'(TIMEOUT) - 1) step("timeout");
        chk("timeout", "tmo_e99", 128'(TIMED_OUT), 128'(1'b0));
        step("timeout");
        chk("timeout", "tmo_e100", 128'(TIMED_OUT), 128'(1'b1));
        chk("timeout", "cpu_rst",  128'(CPU_RST),   128'(1'b1));
        run_to_run();
        repeat (int'(TIMEOUT) - 1) step("tie");
        set_bus(1'b1, TOHOST, 32'd1);
        step("tie");
        chk("tie", "done", 128'(DONE),      128'(1'b1));
        chk("tie", "tmo",  128'(TIMED_OUT), 128'(1'b0));
        set_bus(1'b0, '0, '0);

        // Mid-run asynchronous reset during an interrupt pulse.
        run_to_run();
        set_bus(1'b1, CH_BASE, 32'h0000_00AA);
        step("midrst");
        set_bus(1'b1, CH_BASE + 32'd12, 32'h0000_00BB);
        step("midrst");
        set_bus(1'b0, '0, '0);
        repeat (9) step("midrst");
        chk("midrst", "intr_before", 128'(INTR), 128'(1'b1));
        #3;
        RST = 1'b1;
        model_reset();
        #1;
        chk("midrst", "cpu_rst", 128'(CPU_RST),  128'(1'b1));
        chk("midrst", "intr",    128'(INTR),     128'(1'b0));
        chk("midrst", "data",    CH_DATA,        128'(0));
        chk("midrst", "count",   128'(WR_COUNT), 128'(0));
        repeat (2) step("midrst");
        RST = 1'b0;
        for (int k = 1; k <= int'(RST_CYCLES); k++) begin
            step("rehold");
            if (k == int'(RST_CYCLES) - 1) chk("rehold", "cpu_rst_e14", 128'(CPU_RST), 128'(1'b1));
            if (k == int'(RST_CYCLES))     chk("rehold", "cpu_rst_e15", 128'(CPU_RST), 128'(1'b0));
        end

        // Random traffic against the model.
        for (int run = 0; run < 6; run++) begin
            apply_reset(2);
            for (int k = 0; k < 140; k++) begin
                int sel;
                if ($urandom_range(0, 3) == 0) INTR_REQ = ~INTR_REQ;
                IOBUS_WR  = 1'($urandom_range(0, 1));
                IOBUS_OUT = $urandom;
                sel = int'($urandom_range(0, 9));
                case (sel)
                    4: IOBUS_ADDR = CH_BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
                    5: IOBUS_ADDR = CH_BASE + 32'd16 + 32'(4 * $urandom_range(0, 15));
                    6: begin
                        if (run >= 3 && $urandom_range(0, 5) == 0) begin
                            IOBUS_ADDR = TOHOST;
                            if ($urandom_range(0, 1) == 0) IOBUS_OUT = 32'd1;
                        end else begin
                            IOBUS_ADDR = CH_BASE;
                        end
                    end
                    7: IOBUS_ADDR = $urandom;
                    default: IOBUS_ADDR = CH_BASE + 32'(4 * (sel % 4));
                endcase
                step("rand");
            end
        end
        set_bus(1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
